// File: rtl/tt_debias_collector_if.sv
// rtl/tt_debias_collector_if.sv - key word valid/ready handshake between collector and key stage
interface tt_debias_collector_if #(
    parameter int KEY_W = 4
);
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_out;

    modport master (
        output key_valid,
        output key_out,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_out,
        output key_ready
    );
endinterface

// File: rtl/tt_debias_collector.sv
// rtl/tt_debias_collector.sv - raw entropy sync, von Neumann debias, key packing; TT_HEALTH_TEST_EN adds rep-count health test
module tt_debias_collector #(
    parameter int KEY_W     = 4,
    parameter int REP_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         raw_bit,
    input  logic                         sample_en,
    tt_debias_collector_if.master        key_if,
    output logic                         health_fail
);
    localparam int CW = $clog2(KEY_W + 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             pair_second_q, pair_second_d;
    logic             first_q, first_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0] shift_q, shift_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic [KEY_W-1:0] word;
    logic             fail_d;

`ifdef TT_HEALTH_TEST_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_prev_q, rep_prev_d;
    logic          rep_seen_q, rep_seen_d;
    logic          health_q, health_d;
`endif

    always_comb begin
        state_d       = state_q;
        sync1_d       = raw_bit;
        sync2_d       = sync1_q;
        pair_second_d = pair_second_q;
        first_d       = first_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        key_out_d     = key_out_q;
        word          = {shift_q[KEY_W-2:0], first_q};
        fail_d        = 1'b0;
`ifdef TT_HEALTH_TEST_EN
        rep_cnt_d  = rep_cnt_q;
        rep_prev_d = rep_prev_q;
        rep_seen_d = rep_seen_q;
        // Counter watches every sample, even while a key is parked in HOLD.
        if (sample_en) begin
            rep_seen_d = 1'b1;
            rep_prev_d = sync2_q;
            if (!rep_seen_q || (sync2_q != rep_prev_q)) begin
                rep_cnt_d = RW'(1);
            end else if (rep_cnt_q != RW'(REP_LIMIT)) begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end
        health_d = health_q | (rep_cnt_d == RW'(REP_LIMIT));
        fail_d   = health_d;
`endif

        if (sample_en && (state_q == S_COLLECT)) begin
            if (!pair_second_q) begin
                first_d       = sync2_q;
                pair_second_d = 1'b1;
            end else begin
                pair_second_d = 1'b0;
                // Unequal pair emits its first bit (10 -> 1, 01 -> 0).
                if (first_q != sync2_q) begin
                    shift_d = word;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(KEY_W - 1)) begin
                        cnt_d = '0;
                        if (!fail_d) begin
                            key_out_d = word;
                            state_d   = S_HOLD;
                        end
                    end
                end
            end
        end

        if ((state_q == S_HOLD) && key_if.key_ready) begin
            state_d = S_COLLECT;
        end
        if (fail_d) begin
            state_d = S_COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_COLLECT;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            pair_second_q <= 1'b0;
            first_q       <= 1'b0;
            cnt_q         <= '0;
            shift_q       <= '0;
            key_out_q     <= '0;
`ifdef TT_HEALTH_TEST_EN
            rep_cnt_q     <= '0;
            rep_prev_q    <= 1'b0;
            rep_seen_q    <= 1'b0;
            health_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            pair_second_q <= pair_second_d;
            first_q       <= first_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            key_out_q     <= key_out_d;
`ifdef TT_HEALTH_TEST_EN
            rep_cnt_q     <= rep_cnt_d;
            rep_prev_q    <= rep_prev_d;
            rep_seen_q    <= rep_seen_d;
            health_q      <= health_d;
`endif
        end
    end

    assign key_if.key_valid = (state_q == S_HOLD);
    assign key_if.key_out   = key_out_q;
`ifdef TT_HEALTH_TEST_EN
    assign health_fail = health_q;
`else
    assign health_fail = 1'b0;
`endif
endmodule

// File: tb/tb_tt_debias_collector.sv
// tb/tb_tt_debias_collector.sv - table-driven check of debias collector (KEY_W=4, REP_LIMIT=8)
module tb_tt_debias_collector;
    localparam int KEY_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_bit = 1'b0;
    logic sample_en = 1'b0;
    logic health_fail;

    int vec_cnt = 0;
    int err_cnt = 0;

    tt_debias_collector_if #(.KEY_W(KEY_W)) kif ();

    tt_debias_collector #(.KEY_W(KEY_W), .REP_LIMIT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_bit    (raw_bit),
        .sample_en  (sample_en),
        .key_if     (kif.master),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] bits;
        logic        exp_valid;
        logic [3:0]  exp_key;
        logic        ack;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input logic b);
        raw_bit = b;
        repeat (3) @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        kif.key_ready = 1'b0;
        // bits[n-1] is the first sample
        tbl[0] = '{8,  16'b1001_1010,      1'b1, 4'b1011, 1'b1};
        tbl[1] = '{12, 16'b0010_1101_0110, 1'b1, 4'b1001, 1'b0};
        tbl[2] = '{4,  16'b1010,           1'b1, 4'b1001, 1'b1};
        tbl[3] = '{8,  16'b1010_1010,      1'b1, 4'b1111, 1'b1};
        tbl[4] = '{4,  16'b1001,           1'b0, 4'b1111, 1'b0};

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_valid", 32'(kif.key_valid), 32'd0);
        chk("reset_key", 32'(kif.key_out), 32'h0);
        chk("reset_health", 32'(health_fail), 32'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_valid", 32'(kif.key_valid), 32'd0);
            chk("idle_key", 32'(kif.key_out), 32'h0);
        end

        for (int i = 0; i < 5; i++) begin
            for (int j = tbl[i].n - 1; j >= 0; j--) sample(tbl[i].bits[j]);
            chk($sformatf("v%0d_valid", i), 32'(kif.key_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("v%0d_key", i), 32'(kif.key_out), 32'(tbl[i].exp_key));
            if (tbl[i].exp_valid) begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk($sformatf("v%0d_hold_valid", i), 32'(kif.key_valid), 32'd1);
                    chk($sformatf("v%0d_hold_key", i), 32'(kif.key_out), 32'(tbl[i].exp_key));
                end
            end
            if (tbl[i].ack) begin
                kif.key_ready = 1'b1;
                @(negedge clk);
                kif.key_ready = 1'b0;
                chk($sformatf("v%0d_ack_valid", i), 32'(kif.key_valid), 32'd0);
                chk($sformatf("v%0d_ack_key", i), 32'(kif.key_out), 32'(tbl[i].exp_key));
            end
        end

        // key_ready while collecting must not produce or drop anything
        kif.key_ready = 1'b1;
        @(negedge clk);
        kif.key_ready = 1'b0;
        chk("ready_no_valid", 32'(kif.key_valid), 32'd0);

        do_reset();
        chk("rst2_valid", 32'(kif.key_valid), 32'd0);
        chk("rst2_key", 32'(kif.key_out), 32'h0);
        chk("rst2_health", 32'(health_fail), 32'd0);
        // Only 2 fresh bits: any leftover partial would complete a key here
        sample(1'b0); sample(1'b1); sample(1'b0); sample(1'b1);
        chk("partial_discard", 32'(kif.key_valid), 32'd0);
        sample(1'b0); sample(1'b1); sample(1'b0); sample(1'b1);
        chk("zero_key_valid", 32'(kif.key_valid), 32'd1);
        chk("zero_key", 32'(kif.key_out), 32'h0);

        do_reset();
`ifdef TT_HEALTH_TEST_EN
        for (int k = 0; k < 7; k++) sample(1'b1);
        chk("health_pre", 32'(health_fail), 32'd0);
        sample(1'b1);
        chk("health_trip", 32'(health_fail), 32'd1);
        for (int k = 0; k < 16; k++) begin
            sample(k[0] ? 1'b0 : 1'b1);
            chk("health_block_valid", 32'(kif.key_valid), 32'd0);
        end
        chk("health_sticky", 32'(health_fail), 32'd1);
        do_reset();
        chk("health_cleared", 32'(health_fail), 32'd0);
`else
        for (int k = 0; k < 16; k++) begin
            sample(1'b1);
            chk("no_health", 32'(health_fail), 32'd0);
        end
        chk("ones_no_key", 32'(kif.key_valid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
